fifo_push_arbiter: RTL and testbench
====================================

# fifo_push_arbiter

Shares the single push port of the buffered-UART FIFO between `N_REQ` independent producers (e.g. command echo, status reporter, host bridge). Producers present bursts over valid/ready. A round-robin scheduler grants one producer at a time and forwards its beats into the FIFO while the FIFO is not full. The block is the only writer of the FIFO push side; the pop side is untouched.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, data width, equal to FIFO width
- `MAX_BURST`, 4, maximum beats per grant (1..16)
- `clock` in 1: single clock, all logic on its rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in `N_REQ`: per-requester beat valid
- `req_last` in `N_REQ`: marks the final beat of the requester's burst
- `req_data` in `N_REQ*WIDTH`: requester i occupies bits `[i*WIDTH +: WIDTH]`
- `req_ready` out `N_REQ`: per-requester beat accepted this cycle when also valid
- `fifo_full` in 1: FIFO full flag
- `fifo_push` out 1: push strobe to FIFO
- `fifo_data` out `WIDTH`: data to FIFO
- `grant_valid` out 1: a requester currently holds the grant
- `grant_id` out `$clog2(N_REQ)`: index of the granted requester; 0 when `grant_valid`=0

## Operation
- Two states: IDLE and GRANT.
- IDLE: if any `req_valid` is high, select the first set bit scanning `ptr`, `ptr+1`, …, wrapping modulo `N_REQ`. Register `grant_id`, clear `beat_cnt`, and go to GRANT. If no `req_valid` is high, stay in IDLE.
- GRANT, for granted index g:
  - `req_ready[g] = !fifo_full`; all other `req_ready` bits are 0.
  - `fifo_push = req_valid[g] && !fifo_full`.
  - `fifo_data = req_data[g]` when `fifo_push`, else 0.
- A beat transfers when `fifo_push`=1. Each transfer increments `beat_cnt`.
- Release the grant (go to IDLE, `ptr <= (g+1) mod N_REQ`) on either:
  - a transfer with `req_last[g]`=1, or with `beat_cnt == MAX_BURST-1`;
  - `req_valid[g]`=0 in GRANT. No transfer occurs that cycle.
- While `fifo_full`=1 and `req_valid[g]`=1, hold the grant indefinitely. No push, `beat_cnt` unchanged.
- `req_last` is ignored outside a transferring beat.
- `ptr` is modified only on release, which yields strict round-robin fairness among requesters that keep `valid` asserted.
- Reset mid-burst: the grant is dropped immediately; in-flight requester data is not pushed.

## Timing
- Reset values:
  - state IDLE, `ptr`=0, `beat_cnt`=0, `grant_id`=0
  - `grant_valid`=0, `req_ready`=0, `fifo_push`=0, `fifo_data`=0
- `req_ready`, `fifo_push` and `fifo_data` are combinational from registered state plus `fifo_full` and `req_valid`. There is no register between requester and FIFO, so the FIFO never overflows: a push is never issued while `fifo_full`=1.
- Arbitration latency: a request seen in IDLE at cycle t is granted at t+1. The first push can occur at t+1.
- Back-to-back bursts: release at cycle t, IDLE at t+1, next grant at t+2. Minimum bubble is one idle cycle per burst.
- Throughput within a burst: one beat per cycle while `fifo_full`=0.
- `grant_valid`=1 exactly in GRANT. `grant_id` is stable for the whole grant.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, GRANT);
  - `function automatic rr_pick(req, ptr)` returning index and found flag;
  - a localparam helper `ID_W = $clog2(N_REQ)` pattern, documented for reuse by other arbiters.
- One sub-module is natural: `rr_priority_select`. It is combinational, with `N_REQ` parameter, inputs `req`/`ptr`, outputs `idx`/`found`. It holds the rotate-then-find-first logic so it can be unit-tested and reused on the FIFO pop side later.
- The top holds the FSM, `ptr`, `beat_cnt` and the data mux.

## Test plan
- Single requester 1 sends 3 beats 0x11, 0x22, 0x33 (last on 0x33), FIFO empty. Required: `grant_id`=1 from the cycle after `valid`; pushes on 3 consecutive cycles; release; `ptr`=2.
- All 4 requesters always valid, 1-beat bursts (last=1), from reset. Required: grant order 0,1,2,3,0,… with one IDLE cycle between grants; FIFO receives the matching data sequence.
- Requester 0 holds valid with last=0 for 10 beats, `MAX_BURST`=4. Required: grant released after beat 4; requester 1 (also valid) is granted next; requester 0 regains the grant only after requester 1 is served.
- `fifo_full`=1 for 5 cycles mid-burst of requester 2. Required: `req_ready[2]`=0 and `fifo_push`=0 during the stall; grant is held; the burst resumes with no lost or duplicated beat.
- Granted requester drops `valid` mid-burst. Required: release that cycle with no push; `ptr` advances.
- `reset` asserted during a GRANT with valid high. Required: next cycle all outputs are at reset values, `ptr`=0, and no push is issued.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared types and helpers for the FIFO push arbiter and any other
//            round-robin arbiter in the UART buffer path.
// Contents : arb_state_t  - two-state arbiter FSM encoding
//            id_w()       - index width for an N-way requester vector
//            rr_pick()    - rotate-from-pointer, find-first-set search
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  // Widest requester vector rr_pick() can search; callers zero-extend.
  localparam int MAX_REQ = 8;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Index width for an N-way arbiter. Intended usage in any arbiter:
  //   localparam int ID_W = id_w(N_REQ);
  // Never returns 0, so a degenerate single-requester build still has a
  // legal one-bit index port.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scan req[ptr], req[ptr+1], ... wrapping modulo n; return found flag and
  // the first set index through idx (0 when nothing is set).
  function automatic logic rr_pick(input logic [MAX_REQ-1:0] req,
                                   input int                 ptr,
                                   input int                 n,
                                   output int                idx);
    logic found;
    int   j;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n && !found) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (req[j]) begin
          found = 1'b1;
          idx   = j;
        end
      end
    end
    return found;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_push_arbiter_rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_select
// Purpose  : Combinational round-robin selector: first set request at or
//            after the pointer, wrapping modulo N_REQ.
// Ports    : i_req   [N_REQ-1:0] request vector
//            i_ptr   [ID_W-1:0]  highest-priority index this cycle
//            o_idx   [ID_W-1:0]  selected index (0 when none)
//            o_found             at least one request is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_select
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [id_w(N_REQ)-1:0]   i_ptr,
  output logic [id_w(N_REQ)-1:0]   o_idx,
  output logic                     o_found
);

  localparam int ID_W = id_w(N_REQ);

  logic [MAX_REQ-1:0] w_req_ext;
  int                 w_idx;
  logic               w_found;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[N_REQ-1:0]   = i_req;
    w_idx                  = 0;
    w_found                = rr_pick(w_req_ext, int'(i_ptr), N_REQ, w_idx);
  end

  assign o_idx   = ID_W'(w_idx);
  assign o_found = w_found;

endmodule
`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_push_arbiter
// Purpose  : Round-robin sharing of the UART FIFO push port between N_REQ
//            valid/ready burst producers. One grant at a time, bursts capped
//            at MAX_BURST beats, never pushes while the FIFO is full.
// Ports    : i_clock, i_reset        clock, synchronous active-high reset
//            i_req_valid/last/data   per-requester beat (data i at [i*W+:W])
//            o_req_ready             per-requester accept
//            i_fifo_full             FIFO full flag
//            o_fifo_push/o_fifo_data FIFO push strobe and data
//            o_grant_valid/o_grant_id current grant holder
// Revision : 1.0 - initial release
// ============================================================================
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ-1:0]         i_req_last,
  input  logic [N_REQ*WIDTH-1:0]   i_req_data,
  output logic [N_REQ-1:0]         o_req_ready,
  input  logic                     i_fifo_full,
  output logic                     o_fifo_push,
  output logic [WIDTH-1:0]         o_fifo_data,
  output logic                     o_grant_valid,
  output logic [id_w(N_REQ)-1:0]   o_grant_id
);

  localparam int                ID_W     = id_w(N_REQ);
  localparam int                BEAT_W   = 4;  // holds 0..MAX_BURST-1 for MAX_BURST <= 16
  localparam logic [ID_W-1:0]   C_LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [BEAT_W-1:0] C_MAX_BEAT = BEAT_W'(MAX_BURST - 1);

  arb_state_t        r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_grant_id;
  logic [BEAT_W-1:0] r_beat_cnt;

  logic [ID_W-1:0]   w_sel_idx;
  logic              w_sel_found;
  logic              w_granted;
  logic              w_g_valid;
  logic              w_g_last;
  logic [WIDTH-1:0]  w_g_data;
  logic              w_push;
  logic              w_release;
  logic [ID_W-1:0]   w_next_ptr;

  rr_priority_select #(
    .N_REQ (N_REQ)
  ) u_sel (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_sel_idx),
    .o_found (w_sel_found)
  );

  assign w_granted = (r_state == ARB_GRANT);
  assign w_g_valid = i_req_valid[r_grant_id];
  assign w_g_last  = i_req_last[r_grant_id];
  assign w_g_data  = i_req_data[r_grant_id*WIDTH +: WIDTH];

  // Direct path from requester to FIFO: the full flag gates the push in the
  // same cycle, so no beat can ever be written into a full FIFO.
  assign w_push = w_granted & w_g_valid & ~i_fifo_full;

  // Release on a dropped valid (no transfer) or on the burst's final beat.
  assign w_release = w_granted &
                     (~w_g_valid | (w_push & (w_g_last | (r_beat_cnt == C_MAX_BEAT))));

  assign w_next_ptr = (r_grant_id == C_LAST_ID) ? '0 : r_grant_id + 1'b1;

  always_comb begin
    o_req_ready = '0;
    if (w_granted) o_req_ready[r_grant_id] = ~i_fifo_full;
  end

  assign o_fifo_push   = w_push;
  assign o_fifo_data   = w_push ? w_g_data : '0;
  assign o_grant_valid = w_granted;
  assign o_grant_id    = r_grant_id;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ARB_IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_sel_found) begin
            r_grant_id <= w_sel_idx;
            r_beat_cnt <= '0;
            r_state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (w_release) begin
            // ptr moves only here, giving strict rotation among busy producers
            r_ptr      <= w_next_ptr;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_state    <= ARB_IDLE;
          end else if (w_push) begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_push_arbiter
// Purpose  : Directed vector bench for fifo_push_arbiter (N_REQ=4, WIDTH=8,
//            MAX_BURST=4). Each vector is one clock cycle: inputs driven after
//            the rising edge, outputs and ptr compared on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_push_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        fifo_full, fifo_push, grant_valid;
  logic [7:0]  fifo_data;
  logic [1:0]  grant_id;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_push_arbiter #(
    .N_REQ     (4),
    .WIDTH     (8),
    .MAX_BURST (4)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_req_valid   (req_valid),
    .i_req_last    (req_last),
    .i_req_data    (req_data),
    .o_req_ready   (req_ready),
    .i_fifo_full   (fifo_full),
    .o_fifo_push   (fifo_push),
    .o_fifo_data   (fifo_data),
    .o_grant_valid (grant_valid),
    .o_grant_id    (grant_id)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        full;
    logic [3:0]  ready;
    logic        push;
    logic [7:0]  fdata;
    logic        gv;
    logic [1:0]  gid;
    logic [1:0]  ptr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d, input logic f, input logic [3:0] rdy,
                              input logic p, input logic [7:0] fd, input logic gv,
                              input logic [1:0] gid, input logic [1:0] ptr);
    vec_t t;
    t.rst = r; t.valid = v; t.last = l; t.data = d; t.full = f;
    t.ready = rdy; t.push = p; t.fdata = fd; t.gv = gv; t.gid = gid; t.ptr = ptr;
    return t;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    rst       = v.rst;
    req_valid = v.valid;
    req_last  = v.last;
    req_data  = v.data;
    fifo_full = v.full;
    @(negedge clk);
    n_vec++;
    if (req_ready !== v.ready || fifo_push !== v.push || fifo_data !== v.fdata ||
        grant_valid !== v.gv || grant_id !== v.gid || dut.r_ptr !== v.ptr) begin
      n_err++;
      $display("FAIL %s: got ready=%b push=%b data=%h gv=%b gid=%0d ptr=%0d, exp ready=%b push=%b data=%h gv=%b gid=%0d ptr=%0d",
               tag, req_ready, fifo_push, fifo_data, grant_valid, grant_id, dut.r_ptr,
               v.ready, v.push, v.fdata, v.gv, v.gid, v.ptr);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    // Scenario A: reset state, then requester 1 bursts 11,22,33
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000_1100, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000_1100, 0, 4'b0010, 1, 8'h11, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000_2200, 0, 4'b0010, 1, 8'h22, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 32'h0000_3300, 0, 4'b0010, 1, 8'h33, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 0, 0, 2));
    // Scenario B: all valid, single-beat bursts, rotation with one idle cycle
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 32'hD3D2_D1D0, 0, 4'b0000, 0, 8'h00, 0, 0, 2));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hD3D2_D1D0, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hD3D2_D1D0, 0, 4'b0001, 1, 8'hD0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hD3D2_D1D0, 0, 4'b0000, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hD3D2_D1D0, 0, 4'b0010, 1, 8'hD1, 1, 1, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hD3D2_D1D0, 0, 4'b0000, 0, 8'h00, 0, 0, 2));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hD3D2_D1D0, 0, 4'b0100, 1, 8'hD2, 1, 2, 2));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hD3D2_D1D0, 0, 4'b0000, 0, 8'h00, 0, 0, 3));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hD3D2_D1D0, 0, 4'b1000, 1, 8'hD3, 1, 3, 3));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hD3D2_D1D0, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hD3D2_D1D0, 0, 4'b0001, 1, 8'hD0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 32'hD3D2_D1D0, 0, 4'b0000, 0, 8'h00, 0, 0, 1));
    // Scenario C: requester 0 never sets last, capped at 4 beats; requester 1 served next
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 32'h0000_B0A0, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 4'b0011, 4'b0010, 32'h0000_B0A0, 0, 4'b0001, 1, 8'hA0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 32'h0000_B0A0, 0, 4'b0000, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 32'h0000_B0A0, 0, 4'b0010, 1, 8'hB0, 1, 1, 1));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 32'h0000_B0A0, 0, 4'b0000, 0, 8'h00, 0, 0, 2));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 32'h0000_B0A0, 0, 4'b0001, 1, 8'hA0, 1, 0, 2));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0001, 0, 8'h00, 1, 0, 2));

    // Hold reset for two edges before the first vector so state is defined.
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Scenario D: FIFO full for 5 cycles in the middle of requester 2's burst
    apply(mk(0, 4'b0100, 4'b0000, 32'h00C1_0000, 0, 4'b0000, 0, 8'h00, 0, 0, 0), "stall_req");
    apply(mk(0, 4'b0100, 4'b0000, 32'h00C1_0000, 0, 4'b0100, 1, 8'hC1, 1, 2, 0), "stall_b1");
    for (int i = 0; i < 5; i++)
      apply(mk(0, 4'b0100, 4'b0000, 32'h00C2_0000, 1, 4'b0000, 0, 8'h00, 1, 2, 0),
            $sformatf("stall_full%0d", i));
    apply(mk(0, 4'b0100, 4'b0000, 32'h00C2_0000, 0, 4'b0100, 1, 8'hC2, 1, 2, 0), "stall_b2");
    apply(mk(0, 4'b0100, 4'b0100, 32'h00C3_0000, 0, 4'b0100, 1, 8'hC3, 1, 2, 0), "stall_b3");
    apply(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 0, 0, 3), "stall_rel");

    // Scenario E: requester 1 drops valid mid-burst; ptr 3 -> wraps to 1 -> 2
    apply(mk(0, 4'b0010, 4'b0000, 32'h0000_E100, 0, 4'b0000, 0, 8'h00, 0, 0, 3), "drop_req");
    apply(mk(0, 4'b0010, 4'b0000, 32'h0000_E100, 0, 4'b0010, 1, 8'hE1, 1, 1, 3), "drop_b1");
    apply(mk(0, 4'b0000, 4'b0000, 32'h0000_E200, 0, 4'b0010, 0, 8'h00, 1, 1, 3), "drop_nov");
    apply(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 0, 0, 2), "drop_rel");

    // Scenario F: reset during a grant with valid still high
    apply(mk(0, 4'b0100, 4'b0000, 32'h00F2_0000, 0, 4'b0000, 0, 8'h00, 0, 0, 2), "rst_req");
    apply(mk(0, 4'b0100, 4'b0000, 32'h00F2_0000, 0, 4'b0100, 1, 8'hF2, 1, 2, 2), "rst_b1");
    apply(mk(1, 4'b0100, 4'b0000, 32'h00F2_0000, 1, 4'b0000, 0, 8'h00, 1, 2, 2), "rst_hit");
    apply(mk(0, 4'b0100, 4'b0000, 32'h00F2_0000, 0, 4'b0000, 0, 8'h00, 0, 0, 0), "rst_after");
    apply(mk(0, 4'b0100, 4'b0000, 32'h00F2_0000, 0, 4'b0100, 1, 8'hF2, 1, 2, 0), "rst_regrant");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
